// File: rtl/regbus_arbiter_if.sv
// Shared register-bus handshake between the move requesters and the
// register-bus arbiter.
//   req       : per-requester move request, held until ack
//   req_src   : packed source indices, requester i at [i*IDXW +: IDXW]
//   req_dst   : packed destination indices, same packing
//   gnt       : one-hot grant
//   ack       : one-cycle transfer-complete pulse
//   xfer_err  : pulses with ack when an index is out of range
//   reg_read  : one-hot register read enable (drives the bus)
//   reg_write : one-hot register write enable (captures the bus)
//   busy      : arbiter not idle
// Modports: master = requester/register-bank side, slave = arbiter side.
interface regbus_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned IDXW = 3
) ();
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] req_src;
  logic [NREQ*IDXW-1:0] req_dst;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 xfer_err;
  logic [NREG-1:0]      reg_read;
  logic [NREG-1:0]      reg_write;
  logic                 busy;

  modport master (
    output req, req_src, req_dst,
    input  gnt, ack, xfer_err, reg_read, reg_write, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output gnt, ack, xfer_err, reg_read, reg_write, busy
  );
endinterface

// File: rtl/regbus_arbiter.sv
// Round-robin controller for the shared 16-bit internal register bus.
// Grants one requester at a time and sequences each move as
// SETUP -> XFER -> TURN, so only one register drives the bus and a dead
// cycle always separates consecutive reads.
// Ports:
//   clk   : system clock, all state changes on posedge
//   rst_n : synchronous active-low reset
//   bus   : regbus_arbiter_if.slave (req/req_src/req_dst in,
//           gnt/ack/xfer_err/reg_read/reg_write/busy out)
module regbus_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned IDXW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  regbus_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            xerr_q;
  logic [NREG-1:0] rd_q;
  logic [NREG-1:0] wr_q;
  logic [PW-1:0]   last_q;
  logic [PW-1:0]   win_q;
  logic [IDXW-1:0] src_q;
  logic [IDXW-1:0] dst_q;

  logic            found_d;
  logic [PW-1:0]   win_d;
  logic [PW-1:0]   idx_d;
  logic [NREQ-1:0] gnt_d;
  logic [IDXW-1:0] src_d;
  logic [IDXW-1:0] dst_d;
  logic            in_range_d;
  logic [NREG-1:0] rd_d;
  logic [NREG-1:0] wr_d;

  logic [IDXW-1:0] src_a [NREQ];
  logic [IDXW-1:0] dst_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign src_a[g] = bus.req_src[g*IDXW +: IDXW];
    assign dst_a[g] = bus.req_dst[g*IDXW +: IDXW];
  end

  // Round-robin pick: first set req scanning last+1 .. last+NREQ (mod NREQ),
  // so the requester just served is considered last.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx_d   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx_d = PW'((32'(last_q) + i) % NREQ);
      if (!found_d && bus.req[idx_d]) begin
        found_d = 1'b1;
        win_d   = idx_d;
      end
    end
    gnt_d = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      gnt_d[r] = found_d && (32'(win_d) == r);
    end
    src_d = src_a[win_d];
    dst_d = dst_a[win_d];
  end

  // Strobe decode from the latched indices; an out-of-range index on
  // either side suppresses both strobes for the whole transfer.
  always_comb begin
    in_range_d = (32'(src_q) < NREG) && (32'(dst_q) < NREG);
    rd_d = '0;
    wr_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      rd_d[r] = in_range_d && (32'(src_q) == r);
      wr_d[r] = in_range_d && (32'(dst_q) == r);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      xerr_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      // Pointer at the last requester so requester 0 wins first.
      last_q  <= PW'(NREQ - 1);
      win_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      ack_q  <= '0;
      xerr_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      case (state_q)
        IDLE, TURN: begin
          gnt_q <= '0;
          if (found_d) begin
            state_q <= SETUP;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          // Strobes, ack and error are loaded here so they are registered
          // outputs that are valid exactly during XFER.
          state_q <= XFER;
          rd_q    <= rd_d;
          wr_q    <= wr_d;
          ack_q   <= gnt_q;
          xerr_q  <= !in_range_d;
        end
        XFER: begin
          state_q <= TURN;
          gnt_q   <= '0;
          last_q  <= win_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.xfer_err  = xerr_q;
  assign bus.reg_read  = rd_q;
  assign bus.reg_write = wr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
